fg_stim_gen: RTL and testbench



---
 rtl/fg_stim_gen.sv | 210 +++++++++++++++++++++
 tb/tb_fg_stim_gen.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fg_stim_gen.sv
// Tachometer (FG) stimulus generator: CH phase-staggered square waves with a
// programmable half-period, linear ramping toward a target and counted bursts.
module fg_stim_gen #(
  parameter int CH = 3,
  parameter int PW = 24,
  parameter int BW = 16
) (
  input  logic          CLK1,
  input  logic          RESET_N,
  input  logic          START,
  input  logic          ABORT,
  input  logic          LOAD,
  input  logic [1:0]    MODE_IN,
  input  logic [PW-1:0] HALF_IN,
  input  logic [PW-1:0] TARGET_IN,
  input  logic [PW-1:0] STEP_IN,
  input  logic [PW-1:0] PHASE_IN,
  input  logic [BW-1:0] BURST_IN,
  output logic [CH-1:0] FG,
  output logic          BUSY,
  output logic          DONE,
  output logic [PW-1:0] CUR_HALF
);

  localparam logic [PW-1:0] MIN_HALF = PW'(2);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

  state_t        state_reg;
  state_t        state_next;
  logic          done_reg;
  logic          done_next;

  logic [1:0]    mode_reg;
  logic [PW-1:0] target_reg;
  logic [PW-1:0] step_reg;
  logic [PW-1:0] phase_reg;
  logic [BW-1:0] burst_reg;
  logic [PW-1:0] cur_half_reg;
  logic [PW-1:0] ramp_next;

  logic [CH-1:0] fg_vec;
  logic [CH-1:0] stop_vec;

  logic          busy;
  logic          start_go;
  logic          abort_go;
  logic          burst_mode;
  logic          ramp_mode;
  logic          burst_empty;
  logic          all_stop;
  logic          ch0_rise;
  logic [PW-1:0] start_half;
  logic [PW-1:0] load_half;
  logic [PW-1:0] target_eff;

  assign busy        = (state_reg != ST_IDLE);
  assign start_go    = (state_reg == ST_IDLE) && START && !ABORT;
  assign abort_go    = busy && ABORT;
  assign burst_mode  = (mode_reg == 2'b10);
  assign ramp_mode   = (mode_reg == 2'b01);
  assign burst_empty = burst_mode && (burst_reg == '0);
  assign all_stop    = &stop_vec;
  // A START straight out of reset still needs a legal half-period.
  assign start_half  = (cur_half_reg < MIN_HALF) ? MIN_HALF : cur_half_reg;
  assign load_half   = (HALF_IN < MIN_HALF) ? MIN_HALF : HALF_IN;
  assign target_eff  = (target_reg < MIN_HALF) ? MIN_HALF : target_reg;
  assign ch0_rise    = busy && !abort_go && !stop_vec[0] && !fg_vec[0] &&
                       (g_ch[0].cnt_reg == '0);

  // Step toward the target, landing exactly on it instead of overshooting.
  always_comb begin
    ramp_next = cur_half_reg;
    if (step_reg != '0) begin
      if (cur_half_reg > target_eff) begin
        ramp_next = ((cur_half_reg - target_eff) > step_reg) ?
                    (cur_half_reg - step_reg) : target_eff;
      end else if (cur_half_reg < target_eff) begin
        ramp_next = ((target_eff - cur_half_reg) > step_reg) ?
                    (cur_half_reg + step_reg) : target_eff;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    done_next  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start_go) begin
          if (burst_empty) begin
            done_next = 1'b1;
          end else begin
            state_next = ST_RUN;
          end
        end
      end
      ST_RUN, ST_DRAIN: begin
        if (abort_go) begin
          state_next = ST_IDLE;
        end else if (all_stop) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end else if (stop_vec[0]) begin
          state_next = ST_DRAIN;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK1 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg <= ST_IDLE;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= done_next;
    end
  end

  always_ff @(posedge CLK1 or negedge RESET_N) begin
    if (!RESET_N) begin
      mode_reg   <= '0;
      target_reg <= '0;
      step_reg   <= '0;
      phase_reg  <= '0;
      burst_reg  <= '0;
    end else if (state_reg == ST_IDLE) begin
      if (LOAD && !start_go) begin
        mode_reg   <= MODE_IN;
        target_reg <= TARGET_IN;
        step_reg   <= STEP_IN;
        phase_reg  <= PHASE_IN;
        burst_reg  <= BURST_IN;
      end
    end else if (LOAD && !ABORT) begin
      target_reg <= TARGET_IN;
      step_reg   <= STEP_IN;
    end
  end

  always_ff @(posedge CLK1 or negedge RESET_N) begin
    if (!RESET_N) begin
      cur_half_reg <= '0;
    end else if (start_go) begin
      cur_half_reg <= start_half;
    end else if ((state_reg == ST_IDLE) && LOAD) begin
      cur_half_reg <= load_half;
    end else if (ramp_mode && ch0_rise) begin
      cur_half_reg <= ramp_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      localparam logic [PW+2:0] CH_IDX = (PW+3)'(gi);

      logic [PW-1:0] cnt_reg;
      logic [BW-1:0] fall_reg;
      logic          fg_reg;
      logic          stop_reg;
      logic [PW+2:0] preload_wide;
      logic [PW-1:0] preload;

      // Wide enough for the largest stagger; clip to the counter range.
      assign preload_wide = CH_IDX * {3'b000, phase_reg} + {3'b000, start_half} - (PW+3)'(1);
      assign preload      = (preload_wide[PW+2:PW] != 3'b000) ? '1 : preload_wide[PW-1:0];

      always_ff @(posedge CLK1 or negedge RESET_N) begin
        if (!RESET_N) begin
          cnt_reg  <= '0;
          fall_reg <= '0;
          fg_reg   <= 1'b0;
          stop_reg <= 1'b0;
        end else if (abort_go) begin
          fg_reg <= 1'b0;
        end else if (start_go) begin
          cnt_reg  <= preload;
          fall_reg <= '0;
          fg_reg   <= 1'b0;
          stop_reg <= 1'b0;
        end else if (busy && !stop_reg) begin
          if (cnt_reg == '0) begin
            fg_reg  <= !fg_reg;
            cnt_reg <= cur_half_reg - PW'(1);
            if (fg_reg && burst_mode) begin
              fall_reg <= fall_reg + BW'(1);
              if ((fall_reg + BW'(1)) == burst_reg) begin
                stop_reg <= 1'b1;
              end
            end
          end else begin
            cnt_reg <= cnt_reg - PW'(1);
          end
        end
      end

      assign fg_vec[gi]   = fg_reg;
      assign stop_vec[gi] = stop_reg;
    end
  endgenerate

  assign FG       = fg_vec;
  assign BUSY     = busy;
  assign DONE     = done_reg;
  assign CUR_HALF = cur_half_reg;

endmodule

// File: tb/tb_fg_stim_gen.sv
// Self-checking bench for fg_stim_gen: waveforms are predicted from the
// timing rules (edge times, ramp segment lists) and compared cycle by cycle.
module tb_fg_stim_gen;
  localparam int CH = 3;
  localparam int PW = 24;
  localparam int BW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          load = 1'b0;
  logic [1:0]    mode_in = '0;
  logic [PW-1:0] half_in = '0;
  logic [PW-1:0] target_in = '0;
  logic [PW-1:0] step_in = '0;
  logic [PW-1:0] phase_in = '0;
  logic [BW-1:0] burst_in = '0;
  logic [CH-1:0] fg;
  logic          busy;
  logic          done;
  logic [PW-1:0] cur_half;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fg_stim_gen #(.CH(CH), .PW(PW), .BW(BW)) dut (
    .CLK1(clk), .RESET_N(rst_n), .START(start), .ABORT(abort), .LOAD(load),
    .MODE_IN(mode_in), .HALF_IN(half_in), .TARGET_IN(target_in),
    .STEP_IN(step_in), .PHASE_IN(phase_in), .BURST_IN(burst_in),
    .FG(fg), .BUSY(busy), .DONE(done), .CUR_HALF(cur_half)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_cfg(int mode, int half, int tgt, int st, int ph, int bu);
    mode_in   = 2'(mode);
    half_in   = PW'(half);
    target_in = PW'(tgt);
    step_in   = PW'(st);
    phase_in  = PW'(ph);
    burst_in  = BW'(bu);
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  // Channel k, cycle j after START (j=0 is the first BUSY cycle); b=0 means free-running.
  function automatic logic fg_model(int k, int j, int h, int p, int b);
    int rel;
    rel = j - k * p - h;
    if (rel < 0) return 1'b0;
    if (b > 0 && rel >= (2 * b - 1) * h) return 1'b0;
    return ((rel / h) % 2) == 0;
  endfunction

  function automatic int ramp_step(int cur, int tgt, int st);
    int t;
    t = (tgt < 2) ? 2 : tgt;
    if (st == 0) return cur;
    if (cur > t) return ((cur - t) > st) ? cur - st : t;
    if (cur < t) return ((t - cur) > st) ? cur + st : t;
    return cur;
  endfunction

  task automatic run_check(string name, int h, int p, int b, int ncyc);
    int last;
    last = (CH - 1) * p + 2 * b * h;
    $display("run %s: half=%0d phase=%0d burst=%0d cycles=%0d", name, h, p, b, ncyc);
    start_pulse();
    for (int j = 0; j < ncyc; j++) begin
      logic [CH-1:0] ef;
      logic eb;
      logic ed;
      for (int k = 0; k < CH; k++) ef[k] = fg_model(k, j, h, p, b);
      eb = (b == 0) ? 1'b1 : (j <= last);
      ed = (b > 0) && (j == last + 1);
      checks++;
      if (fg !== ef) begin
        errors++;
        $display("FAIL %s fg j=%0d got %b want %b", name, j, fg, ef);
      end
      checks++;
      if (busy !== eb) begin
        errors++;
        $display("FAIL %s busy j=%0d got %b want %b", name, j, busy, eb);
      end
      checks++;
      if (done !== ed) begin
        errors++;
        $display("FAIL %s done j=%0d got %b want %b", name, j, done, ed);
      end
      if (j == 0) begin
        checks++;
        if (cur_half !== PW'(h)) begin
          errors++;
          $display("FAIL %s cur_half got %0d want %0d", name, cur_half, h);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (fg !== '0 || busy !== 1'b0 || done !== 1'b0 || cur_half !== '0) begin
      errors++;
      $display("FAIL reset got fg=%b busy=%b done=%b cur=%0d want all 0", fg, busy, done, cur_half);
    end
    rst_n = 1'b1;
    tick();
    $display("reset: outputs checked");
  endtask

  task automatic test_continuous();
    load_cfg(0, 4, 0, 0, 2, 0);
    run_check("continuous", 4, 2, 0, 40);
    do_abort();
  endtask

  task automatic test_burst();
    load_cfg(2, 3, 0, 0, 1, 2);
    run_check("burst", 3, 1, 2, 20);
  endtask

  task automatic test_clamp();
    load_cfg(0, 1, 0, 0, 0, 0);
    checks++;
    if (cur_half !== PW'(2)) begin
      errors++;
      $display("FAIL clamp_load cur_half got %0d want 2", cur_half);
    end
    run_check("clamp", 2, 0, 0, 12);
    do_abort();
  endtask

  task automatic test_burst_zero();
    load_cfg(2, 5, 0, 0, 1, 0);
    start_pulse();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || fg !== '0) begin
      errors++;
      $display("FAIL burst_zero first got done=%b busy=%b fg=%b want 1 0 000", done, busy, fg);
    end
    for (int j = 1; j < 12; j++) begin
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || fg !== '0) begin
        errors++;
        $display("FAIL burst_zero j=%0d got done=%b busy=%b fg=%b want 0 0 000", j, done, busy, fg);
      end
    end
    $display("burst_zero: done pulse checked");
  endtask

  task automatic test_ramp(string name, int h, int tgt, int st, int ncyc);
    int exp_fg[$];
    int exp_cur[$];
    int cur;
    int hl;
    cur = (h < 2) ? 2 : h;
    for (int i = 0; i < cur; i++) begin
      exp_fg.push_back(0);
      exp_cur.push_back(cur);
    end
    while (exp_fg.size() < ncyc) begin
      hl  = cur;
      cur = ramp_step(cur, tgt, st);
      for (int i = 0; i < hl; i++) begin
        exp_fg.push_back(1);
        exp_cur.push_back(cur);
      end
      for (int i = 0; i < cur; i++) begin
        exp_fg.push_back(0);
        exp_cur.push_back(cur);
      end
    end
    $display("ramp %s: half=%0d target=%0d step=%0d cycles=%0d", name, h, tgt, st, ncyc);
    load_cfg(1, h, tgt, st, 3, 0);
    start_pulse();
    for (int j = 0; j < ncyc; j++) begin
      checks++;
      if (fg[0] !== 1'(exp_fg[j])) begin
        errors++;
        $display("FAIL %s fg0 j=%0d got %b want %0d", name, j, fg[0], exp_fg[j]);
      end
      checks++;
      if (cur_half !== PW'(exp_cur[j])) begin
        errors++;
        $display("FAIL %s cur_half j=%0d got %0d want %0d", name, j, cur_half, exp_cur[j]);
      end
      tick();
    end
    do_abort();
  endtask

  task automatic test_retarget();
    load_cfg(1, 40, 40, 5, 0, 0);
    start_pulse();
    for (int j = 0; j <= 40; j++) begin
      if (j == 11 || j == 39) begin
        checks++;
        if (cur_half !== PW'(40)) begin
          errors++;
          $display("FAIL retarget hold j=%0d got %0d want 40", j, cur_half);
        end
      end
      if (j == 40) begin
        checks++;
        if (cur_half !== PW'(30) || fg[0] !== 1'b1) begin
          errors++;
          $display("FAIL retarget step got cur=%0d fg0=%b want 30 1", cur_half, fg[0]);
        end
      end
      if (j == 10) begin
        target_in = PW'(20);
        step_in   = PW'(10);
        half_in   = PW'(7);
        mode_in   = 2'b00;
      end
      load = (j == 10);
      tick();
    end
    load = 1'b0;
    do_abort();
    $display("retarget: on-the-fly target/step checked");
  endtask

  task automatic test_abort();
    load_cfg(0, 4, 0, 0, 2, 0);
    start_pulse();
    for (int j = 0; j < 5; j++) tick();
    checks++;
    if (fg[0] !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre fg0 got %b want 1", fg[0]);
    end
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    checks++;
    if (fg !== '0 || busy !== 1'b0 || done !== 1'b0 || cur_half !== PW'(4)) begin
      errors++;
      $display("FAIL abort got fg=%b busy=%b done=%b cur=%0d want 000 0 0 4", fg, busy, done, cur_half);
    end
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    for (int j = 0; j < 8; j++) begin
      checks++;
      if (fg !== '0 || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL abort_idle j=%0d got fg=%b busy=%b done=%b want idle", j, fg, busy, done);
      end
      tick();
    end
    $display("abort: stop and idle start+abort checked");
  endtask

  task automatic test_async_reset();
    load_cfg(1, 20, 8, 3, 1, 0);
    start_pulse();
    for (int j = 0; j < 29; j++) tick();
    checks++;
    if (cur_half !== PW'(17) || busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre got cur=%0d busy=%b want 17 1", cur_half, busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (fg !== '0 || busy !== 1'b0 || done !== 1'b0 || cur_half !== '0) begin
      errors++;
      $display("FAIL rst_async got fg=%b busy=%b done=%b cur=%0d want all 0", fg, busy, done, cur_half);
    end
    tick();
    rst_n = 1'b1;
    tick();
    run_check("rst_restart", 2, 0, 0, 16);
    do_abort();
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int h;
      int p;
      int m;
      int b;
      int sel;
      h   = $urandom_range(1, 9);
      p   = $urandom_range(0, 6);
      sel = $urandom_range(0, 2);
      m   = (sel == 0) ? 0 : (sel == 1) ? 2 : 3;
      b   = (m == 2) ? $urandom_range(1, 3) : 0;
      load_cfg(m, h, $urandom_range(0, 50), $urandom_range(0, 5), p, b);
      if (h < 2) h = 2;
      if (b > 0) begin
        run_check("rand_burst", h, p, b, (CH - 1) * p + 2 * b * h + 4);
      end else begin
        run_check("rand_cont", h, p, 0, (CH - 1) * p + 4 * h + 3);
        do_abort();
      end
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_burst();
    test_clamp();
    test_burst_zero();
    test_ramp("down", 100, 60, 15, 650);
    test_ramp("up", 5, 17, 4, 100);
    test_ramp("low_target", 9, 0, 3, 60);
    test_retarget();
    test_abort();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
